// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared types, default sizes and the address range check used
//             by the regfile_sb register file and its clear sequencer.
//  Contents : clr_state_t   - clear sequencer states
//             RF_DEF_WIDTH  - default data width
//             RF_DEF_DEPTH  - default register count
//             rf_addr_ok()  - 1 when addr selects an existing register
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_t;

    localparam int RF_DEF_WIDTH = 8;
    localparam int RF_DEF_DEPTH = 4;

    // Non-power-of-two depths leave encodable addresses with no register
    // behind them; callers pass both operands widened to 32 bits.
    function automatic logic rf_addr_ok(input logic [31:0] addr,
                                        input logic [31:0] depth);
        return (addr < depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb_if
//  Purpose  : Read/write/issue/clear bus of the regfile_sb register file.
//  Ports    : master - operand fetch / writeback side (drives addresses,
//                      write data, enables, clear request)
//             slave  - the register file (drives read data, valids, BUSY)
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_DEF_WIDTH,
    parameter int AW    = $clog2(RF_DEF_DEPTH)
);
    logic [AW-1:0]    RA1;
    logic [AW-1:0]    RA2;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic             RV1;
    logic             RV2;
    logic [AW-1:0]    RA3;
    logic [WIDTH-1:0] WD3;
    logic             WE3;
    logic [AW-1:0]    IA;
    logic             IE;
    logic             CLR_REQ;
    logic             BUSY;

    modport master (
        output RA1, RA2, RA3, WD3, WE3, IA, IE, CLR_REQ,
        input  RD1, RD2, RV1, RV2, BUSY
    );

    modport slave (
        input  RA1, RA2, RA3, WD3, WE3, IA, IE, CLR_REQ,
        output RD1, RD2, RV1, RV2, BUSY
    );

endinterface
`default_nettype wire

// File: rtl/regfile_sb_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rf_clear_seq
//  Purpose  : Multi-cycle clear sweep. A CLR_REQ seen in IDLE starts a sweep
//             that zeroes one register per cycle, addresses 0..DEPTH-1.
//  Ports    : CLK, reset  - clock, asynchronous active-high reset
//             CLR_REQ     - start request (sampled in IDLE only)
//             BUSY        - sweep in progress (exactly DEPTH cycles)
//             clr_en      - clear register clr_addr at the next edge
//             clr_addr    - register being cleared
//  Revision : 1.0 - initial release
// ============================================================================
module rf_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = RF_DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          CLK,
    input  wire logic          reset,
    input  wire logic          CLR_REQ,
    output logic               BUSY,
    output logic               clr_en,
    output logic [AW-1:0]      clr_addr
);

    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

    clr_state_t    r_state;
    logic [AW-1:0] r_ptr;
    logic          r_busy;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= CLR_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                CLR_IDLE: begin
                    if (CLR_REQ) begin
                        r_state <= CLR_SWEEP;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLR_SWEEP: begin
                    // The edge that clears the last register also ends BUSY.
                    if (r_ptr == c_last_addr) begin
                        r_state <= CLR_IDLE;
                        r_ptr   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= CLR_IDLE;
                    r_ptr   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY     = r_busy;
    assign clr_en   = r_busy;
    assign clr_addr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Two-read / one-write register file with write-through bypass,
//             per-register pending scoreboard, optional hardwired zero
//             register, optional registered read and a clear sweep.
//  Ports    : CLK, reset  - clock, asynchronous active-high reset
//             bus (slave) - RA1/RA2 -> RD1/RD2/RV1/RV2 reads,
//                           RA3/WD3/WE3 write, IA/IE issue,
//                           CLR_REQ -> BUSY clear sweep
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = RF_DEF_WIDTH,
    parameter int DEPTH    = RF_DEF_DEPTH,
    parameter int ZERO_REG = 0,
    parameter int REG_OUT  = 0
) (
    input  wire logic    CLK,
    input  wire logic    reset,
    regfile_sb_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;

    logic             w_busy;
    logic             w_clr_en;
    logic [AW-1:0]    w_clr_addr;

    rf_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .CLK      (CLK),
        .reset    (reset),
        .CLR_REQ  (bus.CLR_REQ),
        .BUSY     (w_busy),
        .clr_en   (w_clr_en),
        .clr_addr (w_clr_addr)
    );

    assign bus.BUSY = w_busy;

    // Writes and issues are dropped while sweeping, for nonexistent
    // registers, and for register 0 when it is hardwired to zero.
    logic w_wr_ok;
    logic w_iss_ok;

    assign w_wr_ok  = bus.WE3 && !w_busy
                   && rf_addr_ok(32'(bus.RA3), 32'(DEPTH))
                   && !((ZERO_REG != 0) && (bus.RA3 == '0));
    assign w_iss_ok = bus.IE && !w_busy
                   && rf_addr_ok(32'(bus.IA), 32'(DEPTH))
                   && !((ZERO_REG != 0) && (bus.IA == '0));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend <= '0;
        end else if (w_clr_en) begin
            r_mem[w_clr_addr]  <= '0;
            r_pend[w_clr_addr] <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_mem[bus.RA3]  <= bus.WD3;
                r_pend[bus.RA3] <= 1'b0;
            end
            // Placed after the write so a same-cycle issue to the written
            // register leaves it pending: the new producer wins.
            if (w_iss_ok) begin
                r_pend[bus.IA] <= 1'b1;
            end
        end
    end

    // Read value resolution, one instance per read port.
    for (genvar p = 0; p < 2; p++) begin : g_rport
        logic [AW-1:0]    w_ra;
        logic [WIDTH-1:0] w_rd;
        logic             w_rv;

        if (p == 0) begin : g_sel_ra1
            assign w_ra = bus.RA1;
        end else begin : g_sel_ra2
            assign w_ra = bus.RA2;
        end

        always_comb begin
            w_rd = '0;
            w_rv = 1'b0;
            if (!rf_addr_ok(32'(w_ra), 32'(DEPTH))) begin
                w_rd = '0;
                w_rv = 1'b0;
            end else if (w_busy) begin
                // Contents stay visible mid-sweep but are never valid.
                w_rd = r_mem[w_ra];
                w_rv = 1'b0;
            end else if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
                w_rv = 1'b1;
            end else if (bus.WE3 && (w_ra == bus.RA3)) begin
                w_rd = bus.WD3;
                w_rv = 1'b1;
            end else begin
                w_rd = r_mem[w_ra];
                w_rv = !r_pend[w_ra];
            end
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [WIDTH-1:0] r_rd1;
        logic [WIDTH-1:0] r_rd2;
        logic             r_rv1;
        logic             r_rv2;

        always_ff @(posedge CLK or posedge reset) begin
            if (reset) begin
                r_rd1 <= '0;
                r_rd2 <= '0;
                r_rv1 <= 1'b0;
                r_rv2 <= 1'b0;
            end else begin
                r_rd1 <= g_rport[0].w_rd;
                r_rd2 <= g_rport[1].w_rd;
                r_rv1 <= g_rport[0].w_rv;
                r_rv2 <= g_rport[1].w_rv;
            end
        end

        assign bus.RD1 = r_rd1;
        assign bus.RD2 = r_rd2;
        assign bus.RV1 = r_rv1;
        assign bus.RV2 = r_rv2;
    end else begin : g_comb_out
        assign bus.RD1 = g_rport[0].w_rd;
        assign bus.RD2 = g_rport[1].w_rd;
        assign bus.RV1 = g_rport[0].w_rv;
        assign bus.RV2 = g_rport[1].w_rv;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Directed self-checking bench for regfile_sb. dut_a is the
//             default 8x4 combinational-read build; dut_b is the 16x6 build
//             with a hardwired zero register and registered reads.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic CLK;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    regfile_sb_if #(.WIDTH(8),  .AW(2)) if_a ();
    regfile_sb_if #(.WIDTH(16), .AW(3)) if_b ();

    regfile_sb #(
        .WIDTH(8), .DEPTH(4), .ZERO_REG(0), .REG_OUT(0)
    ) dut_a (
        .CLK   (CLK),
        .reset (reset),
        .bus   (if_a)
    );

    regfile_sb #(
        .WIDTH(16), .DEPTH(6), .ZERO_REG(1), .REG_OUT(1)
    ) dut_b (
        .CLK   (CLK),
        .reset (reset),
        .bus   (if_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int n_busy;

    initial begin
        reset = 1'b1;
        if_a.RA1 = '0; if_a.RA2 = '0; if_a.RA3 = '0; if_a.WD3 = '0;
        if_a.WE3 = 1'b0; if_a.IA = '0; if_a.IE = 1'b0; if_a.CLR_REQ = 1'b0;
        if_b.RA1 = '0; if_b.RA2 = '0; if_b.RA3 = '0; if_b.WD3 = '0;
        if_b.WE3 = 1'b0; if_b.IA = '0; if_b.IE = 1'b0; if_b.CLR_REQ = 1'b0;

        // ---- reset then reads ----
        step();
        reset = 1'b0;
        if_a.RA1 = 2'd1;
        if_a.RA2 = 2'd2;
        #1;
        check("rst_rd1",  32'(if_a.RD1), 32'h00);
        check("rst_rd2",  32'(if_a.RD2), 32'h00);
        check("rst_rv1",  32'(if_a.RV1), 32'h1);
        check("rst_rv2",  32'(if_a.RV2), 32'h1);
        check("rst_busy", 32'(if_a.BUSY), 32'h0);
        check("rst_b_rv1", 32'(if_b.RV1), 32'h0);
        check("rst_b_rd2", 32'(if_b.RD2), 32'h0000);

        // ---- write with bypass ----
        if_a.WE3 = 1'b1; if_a.RA3 = 2'd3; if_a.WD3 = 8'h03; if_a.RA1 = 2'd3;
        #1;
        check("byp_rd1", 32'(if_a.RD1), 32'h03);
        check("byp_rv1", 32'(if_a.RV1), 32'h1);
        step();
        if_a.WE3 = 1'b0;
        #1;
        check("wr_rd1", 32'(if_a.RD1), 32'h03);
        check("wr_rv1", 32'(if_a.RV1), 32'h1);

        // ---- scoreboard ----
        if_a.IE = 1'b1; if_a.IA = 2'd2;
        step();
        if_a.IE = 1'b0; if_a.RA2 = 2'd2;
        #1;
        check("pend_rv2", 32'(if_a.RV2), 32'h0);
        if_a.WE3 = 1'b1; if_a.RA3 = 2'd2; if_a.WD3 = 8'h5A;
        #1;
        check("sb_byp_rv2", 32'(if_a.RV2), 32'h1);
        check("sb_byp_rd2", 32'(if_a.RD2), 32'h5A);
        step();
        if_a.WE3 = 1'b0;
        #1;
        check("sb_wr_rd2", 32'(if_a.RD2), 32'h5A);
        check("sb_wr_rv2", 32'(if_a.RV2), 32'h1);
        if_a.IE = 1'b1; if_a.IA = 2'd2;
        if_a.WE3 = 1'b1; if_a.RA3 = 2'd2; if_a.WD3 = 8'h77;
        step();
        if_a.IE = 1'b0; if_a.WE3 = 1'b0;
        #1;
        check("same_rv2", 32'(if_a.RV2), 32'h0);
        check("same_rd2", 32'(if_a.RD2), 32'h77);

        // ---- clear sweep ----
        for (int i = 0; i < 4; i++) begin
            if_a.WE3 = 1'b1;
            if_a.RA3 = 2'(i);
            if_a.WD3 = 8'(8'h11 * (i + 1));
            step();
        end
        if_a.WE3 = 1'b0;
        if_a.RA1 = 2'd0; if_a.RA2 = 2'd3;
        #1;
        check("fill_rd1", 32'(if_a.RD1), 32'h11);
        check("fill_rd2", 32'(if_a.RD2), 32'h44);
        check("fill_rv2", 32'(if_a.RV2), 32'h1);
        if_a.CLR_REQ = 1'b1;
        step();
        if_a.CLR_REQ = 1'b0;
        #1;
        n_busy = 0;
        for (int c = 0; c < 20 && if_a.BUSY; c++) begin
            n_busy++;
            check("swp_rv1", 32'(if_a.RV1), 32'h0);
            check("swp_rv2", 32'(if_a.RV2), 32'h0);
            if (c == 0) begin
                check("swp_rd2_old", 32'(if_a.RD2), 32'h44);
            end
            if (c == 3) begin
                // Register 0 is already cleared; this write must be dropped.
                if_a.WE3 = 1'b1; if_a.RA3 = 2'd0; if_a.WD3 = 8'hEE;
            end
            step();
            if_a.WE3 = 1'b0;
            #1;
        end
        check("swp_cycles", 32'(n_busy), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if_a.RA1 = 2'(i);
            #1;
            check("post_clr_rd", 32'(if_a.RD1), 32'h00);
            check("post_clr_rv", 32'(if_a.RV1), 32'h1);
        end

        // ---- reset in the middle of a sweep ----
        if_a.WE3 = 1'b1; if_a.RA3 = 2'd1; if_a.WD3 = 8'h99;
        step();
        if_a.RA3 = 2'd2; if_a.WD3 = 8'hAB;
        step();
        if_a.WE3 = 1'b0;
        if_a.IE = 1'b1; if_a.IA = 2'd2;
        step();
        if_a.IE = 1'b0;
        if_a.RA1 = 2'd1; if_a.RA2 = 2'd2;
        #1;
        check("pre_rst_rd1", 32'(if_a.RD1), 32'h99);
        check("pre_rst_rv2", 32'(if_a.RV2), 32'h0);
        if_a.CLR_REQ = 1'b1;
        step();
        if_a.CLR_REQ = 1'b0;
        step();
        #1;
        check("mid_busy", 32'(if_a.BUSY), 32'h1);
        reset = 1'b1;
        #1;
        check("mrst_busy", 32'(if_a.BUSY), 32'h0);
        check("mrst_rd1",  32'(if_a.RD1), 32'h00);
        check("mrst_rd2",  32'(if_a.RD2), 32'h00);
        check("mrst_rv2",  32'(if_a.RV2), 32'h1);
        reset = 1'b0;
        step();
        check("mrst_busy2", 32'(if_a.BUSY), 32'h0);

        // ---- 16x6, zero register, registered read ----
        if_b.WE3 = 1'b1; if_b.RA3 = 3'd0; if_b.WD3 = 16'hBEEF;
        step();
        if_b.RA3 = 3'd5;
        step();
        if_b.WE3 = 1'b0;
        if_b.IE = 1'b1; if_b.IA = 3'd0;
        step();
        if_b.IE = 1'b0;
        if_b.RA1 = 3'd0; if_b.RA2 = 3'd5;
        #1;
        check("b_lat_rd2", 32'(if_b.RD2), 32'h0000);
        step();
        check("b_z_rd1",  32'(if_b.RD1), 32'h0000);
        check("b_z_rv1",  32'(if_b.RV1), 32'h1);
        check("b_r5_rd2", 32'(if_b.RD2), 32'hBEEF);
        check("b_r5_rv2", 32'(if_b.RV2), 32'h1);
        if_b.RA1 = 3'd7; if_b.RA2 = 3'd6;
        step();
        check("b_oor_rd1", 32'(if_b.RD1), 32'h0000);
        check("b_oor_rv1", 32'(if_b.RV1), 32'h0);
        check("b_oor_rd2", 32'(if_b.RD2), 32'h0000);
        check("b_oor_rv2", 32'(if_b.RV2), 32'h0);
        if_b.WE3 = 1'b1; if_b.RA3 = 3'd4; if_b.WD3 = 16'h1234; if_b.RA2 = 3'd4;
        step();
        if_b.WE3 = 1'b0;
        check("b_byp_rd2", 32'(if_b.RD2), 32'h1234);
        check("b_byp_rv2", 32'(if_b.RV2), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the team's 4x8 two-read/one-write register file.
- Adds the following:
  - configurable width and depth;
  - active-high write enable with write-through bypass;
  - an optional hardwired-zero register;
  - an optional registered-read mode;
  - a per-register pending scoreboard with read-valid flags;
  - a multi-cycle clear sequencer.
- Sits between the datapath ALU/writeback stage and the operand-fetch stage.

Parameters:
- WIDTH, 8: data bits per register.
- DEPTH, 4: number of registers (>=2).
- AW, $clog2(DEPTH): address width. Derived; not overridden.
- ZERO_REG, 0: if 1, register 0 always reads 0 and is never written or marked pending.
- REG_OUT, 0: 0 = combinational read; 1 = read data/valid registered, 1-cycle latency.

Ports:
- CLK  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- RA1  in  AW  read address, port 1.
- RA2  in  AW  read address, port 2.
- RD1  out  WIDTH  read data, port 1.
- RD2  out  WIDTH  read data, port 2.
- RV1  out  1  port-1 data valid (register not pending, or bypassed).
- RV2  out  1  port-2 data valid.
- RA3  in  AW  write address.
- WD3  in  WIDTH  write data.
- WE3  in  1  write enable, active-high.
- IA  in  AW  issue address: register to mark pending.
- IE  in  1  issue enable, active-high.
- CLR_REQ  in  1  start clear sweep (level sampled in IDLE).
- BUSY  out  1  clear sweep in progress.

Behaviour:
- Reset (async, active-high):
  - all registers = 0, all pending bits = 0;
  - FSM = IDLE, BUSY = 0;
  - with REG_OUT=1: RD1/RD2 = 0 and RV1/RV2 = 0 until the first edge after reset release.
- Write: on a rising edge with WE3=1 and BUSY=0, Register[RA3] <= WD3 and pending[RA3] <= 0.
- Issue: on a rising edge with IE=1 and BUSY=0, pending[IA] <= 1.
- Same-cycle write and issue to the same address: data is written and pending ends at 1 (the new producer wins).
- ZERO_REG=1: writes and issues to address 0 are dropped. RDx = 0 and RVx = 1 for address 0.
- Out-of-range address (DEPTH not a power of 2):
  - writes and issues are dropped;
  - reads return RD = 0, RV = 0.
- Combinational read value for port x:
  - If WE3=1, BUSY=0 and RAx==RA3 (and not the zero register): RDx = WD3, RVx = 1 (write-through).
  - Else: RDx = Register[RAx], RVx = !pending[RAx].
  - Both ports resolve independently; RA1==RA2 is legal.
- REG_OUT=0: RDx/RVx follow the read value combinationally.
- REG_OUT=1: RDx/RVx load the read value at each rising edge, including the bypass. The value appears 1 cycle after the address.
- Clear FSM, states IDLE and SWEEP, pointer ptr[AW-1:0]:
  - IDLE: CLR_REQ=1 at an edge -> SWEEP, ptr = 0, BUSY = 1 from that edge.
  - SWEEP, each edge: Register[ptr] <= 0, pending[ptr] <= 0, ptr++.
  - SWEEP: when ptr==DEPTH-1 is cleared -> IDLE, BUSY = 0. The sweep lasts exactly DEPTH cycles.
  - During SWEEP: WE3, IE and CLR_REQ are ignored. Reads return current contents with RV1 = RV2 = 0.
  - Reset mid-sweep: immediate return to IDLE, all state cleared.
- No X propagation: every output is driven from reset onward.

Decomposition:
- Package regfile_pkg holds:
  - typedef enum logic {CLR_IDLE, CLR_SWEEP} clr_state_t;
  - constants RF_DEF_WIDTH = 8 and RF_DEF_DEPTH = 4;
  - function rf_addr_ok(addr, depth), the range check.
- Sub-module rf_clear_seq:
  - contains the FSM and ptr;
  - inputs CLK, reset, CLR_REQ;
  - outputs BUSY, clr_en, clr_addr.
- The top level holds the storage array, pending vector, bypass muxes and REG_OUT stage.

Test Plan:
- Reset then reads:
  - Stimulus: reset=1 for 1 cycle, release; RA1=1, RA2=2.
  - Required: RD1 = RD2 = 0x00, RV1 = RV2 = 1, BUSY = 0.
- Write and bypass:
  - Stimulus: WE3=1, RA3=3, WD3=0x03, RA1=3, all in the same cycle.
  - Required: RD1 = 0x03 and RV1 = 1 before the edge. After the edge with WE3=0: RD1 still 0x03.
- Scoreboard:
  - Stimulus: IE=1, IA=2 for 1 cycle.
  - Required: RA2=2 gives RV2 = 0. Then WE3=1, RA3=2, WD3=0x5A gives RV2 = 1 in that cycle (bypass) and after the edge, RD2 = 0x5A.
  - Stimulus: simultaneous IE=1, IA=2, WE3=1, RA3=2.
  - Required: after the edge, RV2 = 0.
- Clear sweep:
  - Stimulus: fill registers 0..3 with 0x11..0x44, pulse CLR_REQ.
  - Required: BUSY = 1 for exactly 4 cycles, RVx = 0 throughout. A WE3 write issued during the sweep is lost. Afterwards all reads = 0x00.
  - Stimulus: assert reset in the 2nd sweep cycle.
  - Required: BUSY = 0 immediately, all registers 0.
- Parameter sweep:
  - Stimulus: WIDTH=16, DEPTH=6, ZERO_REG=1, REG_OUT=1. Write 0xBEEF to register 0 and to register 5. Read address 7 (out of range).
  - Required: register 0 reads 0x0000 with RV = 1. Register 5 reads 0xBEEF one cycle after its address is applied. Address 7 gives RD = 0, RV = 0.
